// File: rtl/linegen.sv
// UART line generator: emits CR LF terminated lines of a rolling printable pattern through txuart.
// Defining LINEGEN_CHECK_EN adds rxuart and an echo checker that compares received bytes to the same pattern.
module linegen #(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int LINE_LEN        = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [7:0]  i_nlines,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_busy,
  output logic [15:0] o_lines_sent,
  output logic [15:0] o_rx_ok,
  output logic [7:0]  o_rx_err
);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CR, S_LF} state_t;

  localparam logic [6:0] CHAR_LAST = 7'(LINE_LEN - 1);
  localparam logic [7:0] PAT_FIRST = 8'h21;

  function automatic logic [7:0] pat_next(input logic [7:0] p);
    return (p == 8'h7E) ? PAT_FIRST : p + 8'd1;
  endfunction

  state_t     state;
  logic [7:0] nlines;
  logic [7:0] pat;
  logic [6:0] char_cnt;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_busy;
  logic       tx_acc;

  assign tx_stb = (state != S_IDLE);
  assign tx_acc = tx_stb && !tx_busy;
  assign o_busy = tx_stb;

  always_comb begin
    tx_data = pat;
    case (state)
      S_CR:    tx_data = 8'h0D;
      S_LF:    tx_data = 8'h0A;
      default: tx_data = pat;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= S_IDLE;
      nlines       <= 8'h00;
      pat          <= PAT_FIRST;
      char_cnt     <= 7'd0;
      o_lines_sent <= 16'd0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          nlines       <= i_nlines;
          o_lines_sent <= 16'd0;
          pat          <= PAT_FIRST;
          char_cnt     <= 7'd0;
          state        <= S_DATA;
        end
        S_DATA: if (tx_acc) begin
          pat <= pat_next(pat);
          if (char_cnt == CHAR_LAST) begin
            char_cnt <= 7'd0;
            state    <= S_CR;
          end else begin
            char_cnt <= char_cnt + 7'd1;
          end
        end
        S_CR: if (tx_acc) state <= S_LF;
        S_LF: if (tx_acc) begin
          o_lines_sent <= o_lines_sent + 16'd1;
          // nlines of zero never matches, so the run continues until reset
          if (nlines != 8'h00 && (o_lines_sent + 16'd1) == {8'h00, nlines})
            state <= S_IDLE;
          else
            state <= S_DATA;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  txuart #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_tx (
    .i_clk     (i_clk),
    .i_wr      (tx_stb),
    .i_data    (tx_data),
    .o_uart_tx (o_uart_tx),
    .o_busy    (tx_busy)
  );

`ifdef LINEGEN_CHECK_EN
  localparam logic [6:0] POS_CR = 7'(LINE_LEN);
  localparam logic [6:0] POS_LF = 7'(LINE_LEN + 1);

  logic       rx_stb;
  logic [7:0] rx_data;
  logic [7:0] exp_pat;
  logic [6:0] exp_pos;
  logic [7:0] exp_byte;
  logic       start_acc;

  assign start_acc = (state == S_IDLE) && i_start;

  always_comb begin
    exp_byte = exp_pat;
    if (exp_pos == POS_CR)      exp_byte = 8'h0D;
    else if (exp_pos == POS_LF) exp_byte = 8'h0A;
  end

  rxuart #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_rx (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_uart_rx (i_uart_rx),
    .o_wr      (rx_stb),
    .o_data    (rx_data)
  );

  // The expected sequence advances on every received byte, good or bad
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || start_acc) begin
      exp_pat  <= PAT_FIRST;
      exp_pos  <= 7'd0;
      o_rx_ok  <= 16'd0;
      o_rx_err <= 8'd0;
    end else if (rx_stb) begin
      if (rx_data == exp_byte) begin
        if (o_rx_ok != 16'hFFFF) o_rx_ok <= o_rx_ok + 16'd1;
      end else begin
        if (o_rx_err != 8'hFF) o_rx_err <= o_rx_err + 8'd1;
      end
      if (exp_pos < POS_CR) exp_pat <= pat_next(exp_pat);
      exp_pos <= (exp_pos == POS_LF) ? 7'd0 : exp_pos + 7'd1;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = i_uart_rx;
  assign o_rx_ok   = 16'd0;
  assign o_rx_err  = 8'd0;
`endif
endmodule

// 8N1 transmitter without reset; the line is stored inverted so an all-zero
// power-up state is idle with the line high.
module txuart #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       i_clk,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_uart_tx,
  output logic       o_busy
);
  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLOCKS_PER_BAUD - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bits_left;
  logic [8:0]    sh;
  logic          line_n;

  assign o_uart_tx = ~line_n;
  assign o_busy    = (bits_left != 4'd0);

  // bits_left counts start, 8 data and stop periods still to finish
  always_ff @(posedge i_clk) begin
    if (bits_left == 4'd0) begin
      if (i_wr) begin
        line_n    <= 1'b1;
        sh        <= {1'b1, i_data};
        bits_left <= 4'd10;
        baud_cnt  <= BAUD_LAST;
      end
    end else if (baud_cnt != '0) begin
      baud_cnt <= baud_cnt - CW'(1);
    end else begin
      bits_left <= bits_left - 4'd1;
      baud_cnt  <= BAUD_LAST;
      line_n    <= (bits_left == 4'd1) ? 1'b0 : ~sh[0];
      sh        <= sh >> 1;
    end
  end
endmodule

// 8N1 receiver sampling mid-bit; o_wr pulses one cycle per byte with a valid stop bit.
module rxuart #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data
);
  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLOCKS_PER_BAUD / 2 - 1);

  logic [1:0]    sync_n;
  logic          rx_low;
  logic          busy;
  logic [3:0]    bit_idx;
  logic [CW-1:0] cnt;

  assign rx_low = sync_n[1];

  always_ff @(posedge i_clk) begin
    sync_n <= {sync_n[0], ~i_uart_rx};
    if (busy && cnt == '0 && bit_idx >= 4'd1 && bit_idx <= 4'd8)
      o_data <= {~rx_low, o_data[7:1]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      busy    <= 1'b0;
      o_wr    <= 1'b0;
      bit_idx <= 4'd0;
      cnt     <= '0;
    end else begin
      o_wr <= 1'b0;
      if (!busy) begin
        if (rx_low) begin
          busy    <= 1'b1;
          bit_idx <= 4'd0;
          cnt     <= BAUD_HALF;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt     <= BAUD_LAST;
        bit_idx <= bit_idx + 4'd1;
        // a start bit that is gone by mid-bit was a glitch
        if (bit_idx == 4'd0) begin
          if (!rx_low) busy <= 1'b0;
        end else if (bit_idx == 4'd9) begin
          busy <= 1'b0;
          o_wr <= !rx_low;
        end
      end
    end
  end
endmodule

// File: tb/tb_linegen.sv
// Bench for linegen: decodes the serial output, compares every byte with a pattern model,
// and checks counters, busy timing, loopback/corruption and reset behaviour.
module tb_linegen;
  localparam int CPB = 24;
  localparam int LL  = 4;
  localparam int LW  = LL + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  nlines = 8'd0;
  logic        uart_rx;
  logic        uart_tx;
  logic        busy;
  logic [15:0] lines_sent;
  logic [15:0] rx_ok;
  logic [7:0]  rx_err;

  bit   loop_en = 1'b0;
  logic flip = 1'b0;

  always #5 clk = ~clk;
  assign uart_rx = loop_en ? (uart_tx ^ flip) : 1'b1;

  linegen #(.CLOCKS_PER_BAUD(CPB), .LINE_LEN(LL)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_nlines     (nlines),
    .i_uart_rx    (uart_rx),
    .o_uart_tx    (uart_tx),
    .o_busy       (busy),
    .o_lines_sent (lines_sent),
    .o_rx_ok      (rx_ok),
    .o_rx_err     (rx_err)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  int byte_cnt = 0;
  bit chk_en = 1'b0;
  int corrupt_idx = -1;

  // Expected i-th byte of a run: LL pattern bytes then CR LF, pattern rolling over 94 values
  function automatic logic [7:0] model_byte(input int i);
    int pos, pidx;
    pos = i % LW;
    if (pos == LL) return 8'h0D;
    if (pos == LL + 1) return 8'h0A;
    pidx = (i / LW) * LL + pos;
    return 8'(33 + pidx % 94);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial decoder and per-byte compare process; also plants the bit-0 corruption on the echo
  initial begin : decoder
    int off, rel, idx;
    logic [7:0] b;
    bit active;
    active = 1'b0; off = 0; b = 8'h00;
    forever begin
      @(negedge clk);
      if (!active) begin
        flip = 1'b0;
        if (uart_tx === 1'b0) begin
          active = 1'b1;
          off = 0;
        end
      end else begin
        off++;
        rel = off - CPB / 2;
        if (off == CPB / 2) begin
          if (uart_tx !== 1'b0) active = 1'b0;
        end else if (rel > 0 && rel < 9 * CPB && rel % CPB == 0) begin
          idx = rel / CPB - 1;
          b[idx] = uart_tx;
        end else if (rel == 9 * CPB) begin
          active = 1'b0;
          if (chk_en) begin
            check("stop_bit", uart_tx, 1'b1);
            check($sformatf("byte%0d", byte_cnt), b, model_byte(byte_cnt));
            got.push_back(b);
          end
          byte_cnt++;
        end
        flip = active && (byte_cnt == corrupt_idx) && off >= CPB && off < 2 * CPB;
      end
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge; issues a start, checks start latency, waits for the run and its last byte
  task automatic run(input int n, input bit mid_start);
    int c;
    got.delete();
    byte_cnt = 0;
    chk_en = 1'b1;
    nlines = n[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    @(negedge clk);
    check("start_bit_latency", uart_tx, 1'b0);
    if (mid_start) begin
      wait_cycles(300);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    c = 0;
    while (busy && c < n * LW * 10 * CPB * 2 + 200) begin
      @(negedge clk);
      c++;
    end
    check("run_done_in_time", busy, 1'b0);
    wait_cycles(11 * CPB + 10);
    chk_en = 1'b0;
    check("byte_count", got.size(), n * LW);
    check("lines_sent", lines_sent, n);
  endtask

  initial begin
    logic [7:0] pat[$];
    int c;

    // Reset state
    wait_cycles(3);
    check("rst_busy", busy, 1'b0);
    check("rst_lines", lines_sent, 16'd0);
    check("rst_rx_ok", rx_ok, 16'd0);
    check("rst_rx_err", rx_err, 8'd0);
    check("rst_tx_idle", uart_tx, 1'b1);
    rst_n = 1'b1;
    wait_cycles(2);

    // Start on the same edge as reset: reset wins
    rst_n = 1'b0; start = 1'b1; nlines = 8'd1;
    @(negedge clk);
    check("reset_wins_busy", busy, 1'b0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("reset_wins_idle", busy, 1'b0);

    // Single line
    run(1, 1'b0);
    if (got.size() == 6) begin
      check("single_b0", got[0], 8'h21);
      check("single_b1", got[1], 8'h22);
      check("single_b2", got[2], 8'h23);
      check("single_b3", got[3], 8'h24);
      check("single_cr", got[4], 8'h0D);
      check("single_lf", got[5], 8'h0A);
    end

    // Pattern continuity, with a start pulse during the run that must be ignored
    run(2, 1'b1);
    if (got.size() == 12) begin
      check("cont_b0", got[6], 8'h25);
      check("cont_b3", got[9], 8'h28);
      check("cont_cr", got[10], 8'h0D);
      check("cont_lf", got[11], 8'h0A);
    end

    // Pattern wrap after 94 values
    run(24, 1'b0);
    pat.delete();
    foreach (got[i]) if (got[i] != 8'h0D && got[i] != 8'h0A) pat.push_back(got[i]);
    check("wrap_pat_count", pat.size(), 96);
    if (pat.size() == 96) begin
      check("wrap_last_7e", pat[93], 8'h7E);
      check("wrap_back_21", pat[94], 8'h21);
    end
    check("wrap_rx_ok_idle", rx_ok, 16'd0);

    // Loopback
    loop_en = 1'b1;
    run(3, 1'b0);
`ifdef LINEGEN_CHECK_EN
    check("loop_rx_ok", rx_ok, 16'd18);
`else
    check("loop_rx_ok", rx_ok, 16'd0);
`endif
    check("loop_rx_err", rx_err, 8'd0);

    // Corrupted echo of the 2nd byte
    corrupt_idx = 1;
    run(1, 1'b0);
    corrupt_idx = -1;
`ifdef LINEGEN_CHECK_EN
    check("corrupt_rx_ok", rx_ok, 16'd5);
    check("corrupt_rx_err", rx_err, 8'd1);
`else
    check("corrupt_rx_ok", rx_ok, 16'd0);
    check("corrupt_rx_err", rx_err, 8'd0);
`endif

    // Endless run interrupted by reset during line 2
    got.delete();
    byte_cnt = 0;
    chk_en = 1'b1;
    nlines = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (byte_cnt < LW + 2 && c < 20 * 10 * CPB) begin
      @(negedge clk);
      c++;
    end
    check("midrun_reached_line2", (byte_cnt >= LW + 2), 1'b1);
    check("midrun_lines_before", lines_sent, 16'd1);
    check("midrun_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b0;
    check("midrun_busy", busy, 1'b0);
    check("midrun_lines", lines_sent, 16'd0);
    check("midrun_rx_ok", rx_ok, 16'd0);
    check("midrun_rx_err", rx_err, 8'd0);
    wait_cycles(25 * CPB);
    check("midrun_stays_idle", busy, 1'b0);
    run(1, 1'b0);
    if (got.size() > 0) check("restart_first", got[0], 8'h21);
`ifdef LINEGEN_CHECK_EN
    check("restart_rx_ok", rx_ok, 16'd6);
`else
    check("restart_rx_ok", rx_ok, 16'd0);
`endif
    check("restart_rx_err", rx_err, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
